// File: rtl/square_burst_scheduler.sv
// ---------------------------------------------------------------------------
// square_burst_scheduler
//
// Purpose:
//   Sequencer for the 8-bit square-wave output path. A burst command is taken
//   over a valid/ready handshake. The block then emits a counted number of
//   50%-duty square-wave periods at the programmed half-period and amplitude,
//   followed by a programmed run of zero-output idle-gap clocks. A burst can
//   be aborted at any time. A cycle count of zero runs the wave continuously
//   until abort or reset.
//
// Ports:
//   clk             in   1        system clock, all logic on rising edge
//   reset_n         in   1        synchronous reset, active-low
//   cmd_valid       in   1        command present
//   cmd_ready       out  1        accept on edge with cmd_valid && cmd_ready
//   cmd_half_period in   CNT_W    clocks per half period (0 behaves as 1)
//   cmd_cycles      in   BURST_W  full periods per burst (0 = continuous)
//   cmd_amplitude   in   DATA_W   wave_out value during the high half
//   cmd_gap         in   CNT_W    zero-output clocks after the last period
//   abort           in   1        terminate the current burst immediately
//   wave_out        out  DATA_W   registered square-wave sample
//   busy            out  1        registered, high whenever not IDLE
//   burst_done      out  1        registered one-cycle pulse on completion
// ---------------------------------------------------------------------------
module square_burst_scheduler #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CNT_W-1:0]   cmd_half_period,
    input  logic [BURST_W-1:0] cmd_cycles,
    input  logic [DATA_W-1:0]  cmd_amplitude,
    input  logic [CNT_W-1:0]   cmd_gap,
    input  logic               abort,
    output logic [DATA_W-1:0]  wave_out,
    output logic               busy,
    output logic               burst_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] PER_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;        // clocks remaining in current phase, minus one
    logic [BURST_W-1:0] r_per;        // completed full periods
    logic [CNT_W-1:0]   r_half_m1;    // latched half period minus one
    logic [BURST_W-1:0] r_cycles;
    logic [DATA_W-1:0]  r_amp;
    logic [CNT_W-1:0]   r_gap;
    logic [DATA_W-1:0]  r_wave;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic [CNT_W-1:0]   w_cmd_half_m1;
    logic [BURST_W-1:0] w_per_inc;
    logic               w_last_period;

    assign cmd_ready  = (r_state == IDLE) && !abort;
    assign w_accept   = cmd_valid && cmd_ready;

    // A half period of zero is clamped to one clock, so its reload value is 0.
    assign w_cmd_half_m1 = (cmd_half_period == '0) ? '0 : (cmd_half_period - CNT_ONE);

    // The period just being closed is counted before comparing, so a burst of
    // N cycles ends after exactly N LOW halves. Continuous mode never matches.
    assign w_per_inc     = r_per + PER_ONE;
    assign w_last_period = (r_cycles != '0) && (w_per_inc == r_cycles);

    assign wave_out   = r_wave;
    assign busy       = r_busy;
    assign burst_done = r_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_per     <= '0;
            r_half_m1 <= '0;
            r_cycles  <= '0;
            r_amp     <= '0;
            r_gap     <= '0;
            r_wave    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (abort && (r_state != IDLE)) begin
            // Abort drops straight to IDLE without a completion pulse.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wave  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_wave <= '0;
                    if (w_accept) begin
                        r_half_m1 <= w_cmd_half_m1;
                        r_cycles  <= cmd_cycles;
                        r_amp     <= cmd_amplitude;
                        r_gap     <= cmd_gap;
                        r_cnt     <= w_cmd_half_m1;
                        r_per     <= '0;
                        r_state   <= HIGH;
                        r_wave    <= cmd_amplitude;
                        r_busy    <= 1'b1;
                    end
                end

                HIGH: begin
                    if (r_cnt == '0) begin
                        r_state <= LOW;
                        r_cnt   <= r_half_m1;
                        r_wave  <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                LOW: begin
                    if (r_cnt == '0) begin
                        r_per <= w_per_inc;
                        if (w_last_period) begin
                            if (r_gap == '0) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= GAP;
                                r_cnt   <= r_gap - CNT_ONE;
                            end
                        end else begin
                            r_state <= HIGH;
                            r_cnt   <= r_half_m1;
                            r_wave  <= r_amp;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_wave  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
